mvm_sequencer: RTL

//  Sequences the matrix-vector multiply engine for one run per start pulse:

---
 rtl/mvm_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mvm_sequencer.sv
// Run sequencer for the matrix-vector multiply engine: row fetch, byte unpack into FIFOs, MAC drive.
// Optional MVM_PERF_CNT_EN adds a busy-cycle counter on cycle_count.
//
// state    | meaning
// IDLE     | waiting for start after reset
// CLEAR    | one-cycle MAC accumulator clear, row counter reset
// REQ      | memory read request for current row, held through waitrequest
// WAIT     | waiting for readdatavalid of the accepted row
// UNPACK   | DEPTH cycles pushing row bytes LSB first into FIFO[row]
// EXEC     | DEPTH cycles of common FIFO pop
// DRAIN    | covers the final registered mac_en
// DONE     | done held until the next start
module mvm_sequencer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_MAC    = 8,
  parameter int                    DEPTH      = 8,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [ADDR_WIDTH-1:0]       mem_address,
  output logic                        mem_read,
  input  logic                        mem_waitrequest,
  input  logic [DATA_WIDTH*DEPTH-1:0] mem_readdata,
  input  logic                        mem_readdatavalid,
  output logic [NUM_MAC:0]            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_wdata,
  output logic                        fifo_rd_en,
  output logic                        mac_en,
  output logic                        mac_clr,
  output logic                        busy,
  output logic                        done
`ifdef MVM_PERF_CNT_EN
  ,
  output logic [31:0]                 cycle_count
`endif
);

  localparam int ROW_W  = $clog2(NUM_MAC + 1);
  localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WORD_W = DATA_WIDTH * DEPTH;
  localparam logic [NUM_MAC:0] SEL_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_REQ, S_WAIT, S_UNPACK, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  state_t                 state, state_d;
  logic [ROW_W-1:0]       row, row_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic [ADDR_WIDTH-1:0]  mem_address_d;
  logic                   mem_read_d;
  logic [NUM_MAC:0]       fifo_wr_en_d;
  logic                   fifo_rd_en_d;
  logic                   mac_clr_d;
  logic                   busy_d;
  logic                   done_d;

  always_comb begin
    state_d = state;
    row_d   = row;
    cnt_d   = cnt;
    word_d  = word_q;
    wdata_d = '0;
    case (state)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        row_d   = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (!mem_waitrequest) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_readdatavalid) begin
          state_d = S_UNPACK;
          wdata_d = mem_readdata[DATA_WIDTH-1:0];
          word_d  = mem_readdata >> DATA_WIDTH;
          cnt_d   = CNT_W'(DEPTH - 1);
        end
      end
      S_UNPACK: begin
        // cnt counts bytes still to push after the one currently on fifo_wdata
        if (cnt != '0) begin
          cnt_d   = cnt - 1'b1;
          wdata_d = word_q[DATA_WIDTH-1:0];
          word_d  = word_q >> DATA_WIDTH;
        end else if (row == ROW_W'(NUM_MAC)) begin
          state_d = S_EXEC;
          cnt_d   = CNT_W'(DEPTH - 1);
        end else begin
          row_d   = row + 1'b1;
          state_d = S_REQ;
        end
      end
      S_EXEC: begin
        if (cnt != '0) cnt_d = cnt - 1'b1;
        else           state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave flops aligned with the state.
    busy_d        = (state_d inside {[S_CLEAR:S_DRAIN]});
    done_d        = (state_d == S_DONE);
    mac_clr_d     = (state_d == S_CLEAR);
    mem_read_d    = (state_d == S_REQ);
    mem_address_d = mem_read_d ? (BASE_ADDR + ADDR_WIDTH'(row_d)) : '0;
    fifo_wr_en_d  = (state_d == S_UNPACK) ? (SEL_ONE << row_d) : '0;
    fifo_rd_en_d  = (state_d == S_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      row         <= '0;
      cnt         <= '0;
      word_q      <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      fifo_wr_en  <= '0;
      fifo_wdata  <= '0;
      fifo_rd_en  <= 1'b0;
      mac_en      <= 1'b0;
      mac_clr     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      row         <= row_d;
      cnt         <= cnt_d;
      word_q      <= word_d;
      mem_address <= mem_address_d;
      mem_read    <= mem_read_d;
      fifo_wr_en  <= fifo_wr_en_d;
      fifo_wdata  <= wdata_d;
      fifo_rd_en  <= fifo_rd_en_d;
      mac_en      <= fifo_rd_en;
      mac_clr     <= mac_clr_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

`ifdef MVM_PERF_CNT_EN
  // Entering CLEAR only happens on an accepted start, which restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cycle_count <= '0;
    else if (state_d == S_CLEAR) cycle_count <= '0;
    else if (busy)              cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule
